// File: rtl/dct_pkg.sv
// dct_pkg: shared FSM state, block size and the DCT coefficient generator.
package dct_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
    localparam int BLK = 8;
    // 0.5*cos(j*pi/16) scaled by 2^30; entry 4 doubles as c(0)/2 = 1/(2*sqrt2)
    localparam logic [31:0] HALF_COS [9] = '{32'd536870912, 32'd526555088, 32'd496004047,
        32'd446391849, 32'd379625062, 32'd298269498, 32'd205451604, 32'd104738319, 32'd0};

    function automatic logic signed [31:0] dct_coef(input logic [2:0] k, input logic [2:0] n,
                                                    input int coef_w);
        logic [4:0] m;
        logic neg;
        logic [31:0] v;
        m = 5'((32'(n) * 2 + 1) * 32'(k));
        m = m > 5'd16 ? 5'(6'd32 - 6'(m)) : m;
        neg = m > 5'd8;
        v = HALF_COS[k == 3'd0 ? 4'd4 : neg ? 4'(5'd16 - m) : 4'(m)];
        v = (v + (32'd1 << (30 - coef_w))) >> (31 - coef_w);
        return neg ? -$signed(v) : $signed(v);
    endfunction
endpackage

// File: rtl/dct_coef_rom.sv
// dct_coef_rom: combinational C[k][n] lookup in signed Q1.(COEF_W-1).
module dct_coef_rom
    import dct_pkg::*;
#(
    parameter int COEF_W = 12
) (
    input  logic [2:0]               k_i,
    input  logic [2:0]               n_i,
    output logic signed [COEF_W-1:0] coef_o
);
    always_comb coef_o = COEF_W'(dct_coef(k_i, n_i, COEF_W));
endmodule

// File: rtl/dct_idct_engine.sv
// dct_idct_engine: 8-point forward/inverse DCT using one serial multiply-accumulate.
// Define DCT_ROUND_EN to round half-up before the output shift; otherwise it truncates.
module dct_idct_engine
    import dct_pkg::*;
#(
    parameter int DIN_W  = 8,
    parameter int DOUT_W = 12,
    parameter int COEF_W = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic              out_last,
    output logic              out_mode
);
    localparam int ACC_W = DIN_W + COEF_W + 3;
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'(2 ** (DOUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(-(2 ** (DOUT_W - 1)));

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q;
    logic mode_q, in_hs, out_hs, out_last_q, out_mode_q;
    logic signed [DIN_W-1:0] buf_q [BLK];
    logic signed [ACC_W-1:0] acc_q, rnd, shf;
    logic signed [COEF_W-1:0] coef;
    logic signed [DIN_W+COEF_W-1:0] prod;
    logic [DOUT_W-1:0] res, out_data_q;

    // DCT sweeps n for a fixed k; IDCT sweeps k for a fixed output n, so the ROM indices swap
    dct_coef_rom #(.COEF_W(COEF_W)) u_rom (
        .k_i    (mode_q ? cnt_q[2:0] : idx_q),
        .n_i    (mode_q ? idx_q : cnt_q[2:0]),
        .coef_o (coef)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_hs ? LOAD : IDLE;
            LOAD:    state_d = (in_hs && cnt_q == 4'd7) ? CALC : LOAD;
            CALC:    state_d = cnt_q == 4'd8 ? OUT : CALC;
            OUT:     state_d = out_hs ? (idx_q == 3'd7 ? IDLE : CALC) : OUT;
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q;
        if (in_hs) cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
        if (state_q == CALC) cnt_d = cnt_q == 4'd8 ? 4'd0 : cnt_q + 4'd1;
    end

    always_comb begin
        in_ready  = state_q == IDLE || state_q == LOAD;
        out_valid = state_q == OUT;
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        out_data  = out_data_q;
        out_last  = out_last_q;
        out_mode  = out_mode_q;
    end

    always_comb begin
        prod = buf_q[cnt_q[2:0]] * coef;
`ifdef DCT_ROUND_EN
        rnd = acc_q + (ACC_W'(1) <<< (COEF_W - 2));
`else
        rnd = acc_q;
`endif
        shf = rnd >>> (COEF_W - 1);
        res = shf > OMAX ? DOUT_W'(OMAX) : shf < OMIN ? DOUT_W'(OMIN) : DOUT_W'(shf);
    end

    // CALC spends counts 0..7 on products and count 8 registering the scaled result
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            mode_q     <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_mode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_hs) buf_q[cnt_q[2:0]] <= in_data;
            if (in_hs && state_q == IDLE) mode_q <= in_mode;
            if (state_q == CALC && cnt_q != 4'd8) acc_q <= acc_q + ACC_W'(prod);
            if (state_q == CALC && cnt_q == 4'd8) begin
                out_data_q <= res;
                out_last_q <= idx_q == 3'd7;
                out_mode_q <= mode_q;
            end
            if (out_hs) begin
                acc_q <= '0;
                idx_q <= idx_q + 3'd1;
            end
        end
    end
endmodule
